// File: rtl/aes_kexp_pkg.sv
// rtl/aes_kexp_pkg.sv - AES key schedule constants: S-box, Rcon, FSM states, Nk/Ntot.
package aes_kexp_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } kexp_state_e;

  localparam logic [3:0] NK128   = 4'd4;
  localparam logic [3:0] NK192   = 4'd6;
  localparam logic [3:0] NK256   = 4'd8;
  localparam logic [5:0] NTOT128 = 6'd44;
  localparam logic [5:0] NTOT192 = 6'd52;
  localparam logic [5:0] NTOT256 = 6'd60;

  // Indexed by the round number i/Nk; entries 0 and 11..15 are never used.
  localparam logic [0:15][7:0] RCON = 128'h00_01020408102040801b36_0000000000;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: four parallel AES S-box lookups, purely combinational.
module aes_sub_word
  import aes_kexp_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES key schedule generator, one word per cycle into a readable array.
// Define AES_KEY256_EN for AES-192/256 support (60-word store); otherwise AES-128 only (44 words).
module aes_key_expand
  import aes_kexp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  input  logic [6:0]   rd_idx,
  output logic [31:0]  rd_word
);

`ifdef AES_KEY256_EN
  localparam int DEPTH = int'(NTOT256);
`else
  localparam int DEPTH = int'(NTOT128);
`endif

  kexp_state_e r_state, w_next_state;
  logic [31:0] r_w [0:DEPTH-1];
  logic [3:0]  r_nk;
  logic [5:0]  r_ntot;
  logic [5:0]  r_i;
  logic [2:0]  r_phase;
  logic [3:0]  r_round;
  logic        r_done;

  logic [3:0]  w_nk;
  logic [5:0]  w_ntot;
  logic        w_load;
  logic        w_last;
  logic [31:0] w_prev, w_base, w_sub_in, w_sub_out, w_temp;

  always_comb begin
    w_nk   = NK128;
    w_ntot = NTOT128;
`ifdef AES_KEY256_EN
    if (key_len == 2'd1) begin
      w_nk   = NK192;
      w_ntot = NTOT192;
    end else if (key_len == 2'd2) begin
      w_nk   = NK256;
      w_ntot = NTOT256;
    end
`endif
  end

`ifndef AES_KEY256_EN
  logic w_unused;
  assign w_unused = ^{key_len, key[127:0]};
`endif

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_last = (r_state == ST_EXPAND) && (r_i == r_ntot - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_IDLE) begin
      if (start) w_next_state = ST_EXPAND;
    end else if (w_last) begin
      w_next_state = ST_IDLE;
    end
  end

  assign w_prev   = r_w[r_i - 6'd1];
  assign w_base   = r_w[r_i - {2'b00, r_nk}];
  assign w_sub_in = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_phase == 3'd0) begin
      w_temp = w_sub_out ^ {RCON[r_round], 24'h0};
    end
`ifdef AES_KEY256_EN
    else if (r_nk == NK256 && r_phase == 3'd4) begin
      w_temp = w_sub_out;
    end
`endif
  end

  // Phase tracks i mod Nk and round tracks i/Nk, so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_w[k] <= '0;
      r_nk    <= '0;
      r_ntot  <= '0;
      r_i     <= '0;
      r_phase <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        for (int k = 0; k < DEPTH; k++) r_w[k] <= '0;
        for (int k = 0; k < 8; k++) begin
          if (4'(k) < w_nk) r_w[k] <= key[255-32*k -: 32];
        end
        r_nk    <= w_nk;
        r_ntot  <= w_ntot;
        r_i     <= {2'b00, w_nk};
        r_phase <= 3'd0;
        r_round <= 4'd1;
      end else if (r_state == ST_EXPAND) begin
        r_w[r_i] <= w_base ^ w_temp;
        r_i      <= r_i + 6'd1;
        if ({1'b0, r_phase} == r_nk - 4'd1) begin
          r_phase <= 3'd0;
          r_round <= r_round + 4'd1;
        end else begin
          r_phase <= r_phase + 3'd1;
        end
      end
    end
  end

  assign busy    = (r_state == ST_EXPAND);
  assign done    = r_done;
  assign rd_word = (rd_idx < 7'(DEPTH)) ? r_w[rd_idx[5:0]] : 32'h0;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - self-checking bench for aes_key_expand against a GF(2^8)-derived key schedule model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         busy, done;
  logic [6:0]   rd_idx = '0;
  logic [31:0]  rd_word;

  int errors = 0;
  int checks = 0;
  logic [7:0]  sb [0:255];
  logic [31:0] exp_w [0:59];
  int          ntot_m;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_0badf00d_12345678_9abcdef0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_len (key_len),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .rd_idx  (rd_idx),
    .rd_word (rd_word)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    ntot_m = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) exp_w[i] = k[255-32*i -: 32];
    for (int i = nk; i < ntot_m; i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = xtime(rc);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sweep(input string tag, input int valid);
    for (int i = 0; i < 128; i++) begin
      rd_idx = 7'(i);
      #1;
      chk($sformatf("%s w[%0d]", tag, i), rd_word, (i < valid) ? exp_w[i] : 32'h0);
    end
  endtask

  task automatic lit(input string tag, input int idx, input logic [31:0] val);
    chk($sformatf("%s model w[%0d]", tag, idx), exp_w[idx], val);
    rd_idx = 7'(idx);
    #1;
    chk($sformatf("%s dut w[%0d]", tag, idx), rd_word, val);
  endtask

  // Runs one expansion from a start; checks busy/done and word fill every cycle.
  task automatic run(input string tag, input logic [255:0] k, input logic [1:0] kl, input int nk,
                     input bit pre, input bit hammer, input bit chain, input int abort_at);
    int lat;
    build_model(k, nk);
    lat = ntot_m - nk + 1;
    if (!pre) @(negedge clk);
    key = k;
    key_len = kl;
    start = 1'b1;
    for (int m = 1; m <= lat; m++) begin
      @(negedge clk);
      if (m == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk($sformatf("%s abort busy", tag), {31'h0, busy}, 32'h0);
        chk($sformatf("%s abort done", tag), {31'h0, done}, 32'h0);
        sweep({tag, " abort"}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("%s idle busy", tag), {31'h0, busy}, 32'h0);
        return;
      end
      #1;
      chk($sformatf("%s c%0d busy", tag, m), {31'h0, busy}, {31'h0, m < lat});
      chk($sformatf("%s c%0d done", tag, m), {31'h0, done}, {31'h0, m == lat});
      if (m < lat) begin
        rd_idx = 7'(nk + m - 2);
        #1;
        chk($sformatf("%s c%0d w[%0d]", tag, m, nk + m - 2), rd_word, exp_w[nk + m - 2]);
        rd_idx = 7'(nk + m - 1);
        #1;
        chk($sformatf("%s c%0d w[%0d]", tag, m, nk + m - 1), rd_word, 32'h0);
      end
      start   = (hammer && m < lat) || (chain && m == lat);
      key     = (m == lat) ? k : ~k;
      key_len = (m == lat) ? kl : ~kl;
    end
    if (!chain) begin
      start = 1'b0;
      sweep(tag, ntot_m);
      chk($sformatf("%s post done", tag), {31'h0, done}, 32'h0);
      chk($sformatf("%s post busy", tag), {31'h0, busy}, 32'h0);
    end
  endtask

  initial begin
    build_sbox();
    #2;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    sweep("reset", 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef AES_KEY256_EN
    run("aes256", K256, 2'd2, 8, 1'b0, 1'b0, 1'b0, 0);
    lit("aes256", 8,  32'h9ba35411);
    lit("aes256", 12, 32'ha8b09c1a);
    lit("aes256", 59, 32'h706c631e);
    run("aes128", K128, 2'd0, 4, 1'b0, 1'b0, 1'b0, 0);
    lit("aes128", 4,  32'ha0fafe17);
    lit("aes128", 5,  32'h88542cb1);
    lit("aes128", 7,  32'h2a6c7605);
    lit("aes128", 43, 32'hb6630ca6);
    run("aes192", K192, 2'd1, 6, 1'b0, 1'b0, 1'b0, 0);
    lit("aes192", 6,  32'hfe0c91f7);
    lit("aes192", 51, 32'h01002202);
    run("klen3", K128, 2'd3, 4, 1'b0, 1'b0, 1'b0, 0);
    lit("klen3", 43, 32'hb6630ca6);
    run("hammer", K256, 2'd2, 8, 1'b0, 1'b1, 1'b0, 0);
    run("abort", K192, 2'd1, 6, 1'b0, 1'b0, 1'b0, 20);
    run("fresh", K192, 2'd1, 6, 1'b0, 1'b0, 1'b0, 0);
    lit("fresh", 51, 32'h01002202);
    run("chain1", K256, 2'd2, 8, 1'b0, 1'b0, 1'b1, 0);
    run("chain2", K128, 2'd0, 4, 1'b1, 1'b0, 1'b0, 0);
`else
    run("aes128", K128, 2'd0, 4, 1'b0, 1'b0, 1'b0, 0);
    lit("aes128", 4,  32'ha0fafe17);
    lit("aes128", 5,  32'h88542cb1);
    lit("aes128", 7,  32'h2a6c7605);
    lit("aes128", 43, 32'hb6630ca6);
    run("klen2", K128, 2'd2, 4, 1'b0, 1'b0, 1'b0, 0);
    run("klen3", K128, 2'd3, 4, 1'b0, 1'b0, 1'b0, 0);
    lit("klen3", 43, 32'hb6630ca6);
    run("hammer", K128, 2'd0, 4, 1'b0, 1'b1, 1'b0, 0);
    run("abort", K128, 2'd0, 4, 1'b0, 1'b0, 1'b0, 20);
    run("fresh", K128, 2'd0, 4, 1'b0, 1'b0, 1'b0, 0);
    lit("fresh", 43, 32'hb6630ca6);
    run("chain1", ~K128, 2'd0, 4, 1'b0, 1'b0, 1'b1, 0);
    run("chain2", K128, 2'd0, 4, 1'b1, 1'b0, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
